// File: rtl/reg_file_fwd_if.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_fwd_if
// Purpose  : ID-stage register-file bundle: read ports, EX/MEM forward
//            sources, WB write port and the load-use stall request.
// Revision : 1.0
// ============================================================================
interface reg_file_fwd_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                  read_en_1;
    logic [ADDR_WIDTH-1:0] read_addr_1;
    logic                  read_en_2;
    logic [ADDR_WIDTH-1:0] read_addr_2;
    logic [DATA_WIDTH-1:0] read_data_1;
    logic [DATA_WIDTH-1:0] read_data_2;
    logic                  ex_write_en;
    logic [ADDR_WIDTH-1:0] ex_write_addr;
    logic [DATA_WIDTH-1:0] ex_write_data;
    logic                  ex_load;
    logic                  mem_write_en;
    logic [ADDR_WIDTH-1:0] mem_write_addr;
    logic [DATA_WIDTH-1:0] mem_write_data;
    logic                  write_en;
    logic [ADDR_WIDTH-1:0] write_addr;
    logic [DATA_WIDTH-1:0] write_data;
    logic                  stall_request;

    modport master (
        output read_en_1, read_addr_1, read_en_2, read_addr_2,
        output ex_write_en, ex_write_addr, ex_write_data, ex_load,
        output mem_write_en, mem_write_addr, mem_write_data,
        output write_en, write_addr, write_data,
        input  read_data_1, read_data_2, stall_request
    );

    modport slave (
        input  read_en_1, read_addr_1, read_en_2, read_addr_2,
        input  ex_write_en, ex_write_addr, ex_write_data, ex_load,
        input  mem_write_en, mem_write_addr, mem_write_data,
        input  write_en, write_addr, write_data,
        output read_data_1, read_data_2, stall_request
    );
endinterface
`default_nettype wire

// File: rtl/reg_file_fwd.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_fwd
// Purpose  : Register file with EX > MEM > WB operand forwarding and a
//            combinational load-use stall request.
// Revision : 1.0
// ============================================================================
module reg_file_fwd #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  wire logic       clk,
    input  wire logic       rst,
    reg_file_fwd_if.slave   bus
);
    localparam int C_NUM_REGS = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [C_NUM_REGS];

    // r0 is only ever cleared by reset; reads of it are forced to zero anyway.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < C_NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (bus.write_en && (bus.write_addr != '0)) begin
            regs_q[bus.write_addr] <= bus.write_data;
        end
    end

    generate
        for (genvar p = 0; p < 2; p++) begin : g_port
            logic                  rd_en;
            logic [ADDR_WIDTH-1:0] rd_addr;
            logic [DATA_WIDTH-1:0] rd_data;
            logic                  hazard;

            assign rd_en   = (p == 0) ? bus.read_en_1   : bus.read_en_2;
            assign rd_addr = (p == 0) ? bus.read_addr_1 : bus.read_addr_2;

            // Youngest producer wins; a load still in EX has no data yet.
            always_comb begin
                rd_data = '0;
                hazard  = 1'b0;
                if (!rst && rd_en && (rd_addr != '0)) begin
                    if (bus.ex_write_en && (bus.ex_write_addr == rd_addr)) begin
                        if (bus.ex_load) begin
                            hazard = 1'b1;
                        end else begin
                            rd_data = bus.ex_write_data;
                        end
                    end else if (bus.mem_write_en && (bus.mem_write_addr == rd_addr)) begin
                        rd_data = bus.mem_write_data;
                    end else if (bus.write_en && (bus.write_addr == rd_addr)) begin
                        rd_data = bus.write_data;
                    end else begin
                        rd_data = regs_q[rd_addr];
                    end
                end
            end
        end
    endgenerate

    assign bus.read_data_1   = g_port[0].rd_data;
    assign bus.read_data_2   = g_port[1].rd_data;
    assign bus.stall_request = g_port[0].hazard | g_port[1].hazard;

endmodule
`default_nettype wire

// File: tb/tb_reg_file_fwd.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_file_fwd
// Purpose  : Directed bench for reg_file_fwd with a per-cycle reference model.
// Revision : 1.0
// ============================================================================
module tb_reg_file_fwd;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    reg_file_fwd_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();

    reg_file_fwd #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference: plain array plus an ordered list of producers, youngest first.
    logic [31:0] model [32];
    initial for (int i = 0; i < 32; i++) model[i] = 32'h0;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) model[i] = 32'h0;
        end else if (bus.write_en && bus.write_addr != 5'd0) begin
            model[bus.write_addr] = bus.write_data;
        end
    end

    typedef struct {
        bit          valid;
        logic [4:0]  addr;
        logic [31:0] data;
        bit          pending;
    } prod_t;

    function automatic logic [32:0] predict(input logic en, input logic [4:0] addr);
        prod_t q[$];
        if (rst || !en || addr == 5'd0) return 33'h0;
        q.push_back('{bus.ex_write_en,  bus.ex_write_addr,  bus.ex_write_data,  bus.ex_load});
        q.push_back('{bus.mem_write_en, bus.mem_write_addr, bus.mem_write_data, 1'b0});
        q.push_back('{bus.write_en,     bus.write_addr,     bus.write_data,     1'b0});
        foreach (q[i]) begin
            if (q[i].valid && q[i].addr == addr)
                return q[i].pending ? {1'b1, 32'h0} : {1'b0, q[i].data};
        end
        return {1'b0, model[addr]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [32:0] p1, p2;
        p1 = predict(bus.read_en_1, bus.read_addr_1);
        p2 = predict(bus.read_en_2, bus.read_addr_2);
        check("model_rd1",   bus.read_data_1, p1[31:0]);
        check("model_rd2",   bus.read_data_2, p2[31:0]);
        check("model_stall", {31'h0, bus.stall_request}, {31'h0, p1[32] | p2[32]});
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle();
        bus.read_en_1 = 0; bus.read_addr_1 = 0; bus.read_en_2 = 0; bus.read_addr_2 = 0;
        bus.ex_write_en = 0; bus.ex_write_addr = 0; bus.ex_write_data = 0; bus.ex_load = 0;
        bus.mem_write_en = 0; bus.mem_write_addr = 0; bus.mem_write_data = 0;
        bus.write_en = 0; bus.write_addr = 0; bus.write_data = 0;
    endtask

    initial begin
        idle();
        // Reset with a write and an EX load hazard both present.
        rst = 1;
        bus.write_en = 1; bus.write_addr = 5; bus.write_data = 32'hDEADBEEF;
        bus.ex_write_en = 1; bus.ex_load = 1; bus.ex_write_addr = 5;
        bus.read_en_1 = 1; bus.read_addr_1 = 5;
        settle();
        check("rst_rd1", bus.read_data_1, 32'h0);
        check("rst_stall", {31'h0, bus.stall_request}, 32'h0);
        cyc();
        check("rst_stall2", {31'h0, bus.stall_request}, 32'h0);
        cyc();
        idle(); rst = 0;
        bus.read_en_1 = 1; bus.read_addr_1 = 5;
        settle();
        check("post_rst_r5", bus.read_data_1, 32'h0);
        check("post_rst_stall", {31'h0, bus.stall_request}, 32'h0);

        // Write r8 then attempt r0.
        cyc(); idle();
        bus.write_en = 1; bus.write_addr = 8; bus.write_data = 32'h12345678;
        cyc();
        bus.write_addr = 0; bus.write_data = 32'hFFFFFFFF;
        cyc(); idle();
        bus.read_en_1 = 1; bus.read_addr_1 = 8;
        bus.read_en_2 = 1; bus.read_addr_2 = 0;
        settle();
        check("rd_r8", bus.read_data_1, 32'h12345678);
        check("rd_r0", bus.read_data_2, 32'h0);

        // WB write-through bypass.
        cyc(); idle();
        bus.write_en = 1; bus.write_addr = 9; bus.write_data = 32'hA5A5A5A5;
        bus.read_en_2 = 1; bus.read_addr_2 = 9;
        settle();
        check("wb_bypass", bus.read_data_2, 32'hA5A5A5A5);
        cyc(); bus.write_en = 0;
        settle();
        check("r9_array", bus.read_data_2, 32'hA5A5A5A5);

        // Forwarding priority on r3.
        cyc(); idle();
        bus.write_en = 1; bus.write_addr = 3; bus.write_data = 32'h1;
        cyc();
        bus.read_en_1 = 1; bus.read_addr_1 = 3;
        bus.ex_write_en = 1; bus.ex_write_addr = 3; bus.ex_write_data = 32'h33;
        bus.mem_write_en = 1; bus.mem_write_addr = 3; bus.mem_write_data = 32'h22;
        bus.write_data = 32'h11;
        settle();
        check("prio_ex", bus.read_data_1, 32'h33);
        cyc(); bus.ex_write_en = 0;
        settle();
        check("prio_mem", bus.read_data_1, 32'h22);
        cyc(); bus.mem_write_en = 0;
        settle();
        check("prio_wb", bus.read_data_1, 32'h11);
        cyc(); bus.write_en = 0;
        settle();
        check("r3_array", bus.read_data_1, 32'h11);

        // Load-use on port 2 then MEM forwarding.
        cyc(); idle();
        bus.ex_write_en = 1; bus.ex_load = 1; bus.ex_write_addr = 4;
        bus.read_en_2 = 1; bus.read_addr_2 = 4;
        settle();
        check("lu_stall", {31'h0, bus.stall_request}, 32'h1);
        check("lu_data0", bus.read_data_2, 32'h0);
        cyc();
        bus.ex_write_en = 0; bus.ex_load = 0;
        bus.mem_write_en = 1; bus.mem_write_addr = 4; bus.mem_write_data = 32'h77;
        settle();
        check("lu_nostall", {31'h0, bus.stall_request}, 32'h0);
        check("lu_mem_fwd", bus.read_data_2, 32'h77);

        // Disabled port and r0 read against an EX load.
        cyc(); idle();
        bus.ex_write_en = 1; bus.ex_load = 1; bus.ex_write_addr = 4;
        bus.read_en_1 = 0; bus.read_addr_1 = 4;
        bus.read_en_2 = 1; bus.read_addr_2 = 8;
        settle();
        check("dis_stall", {31'h0, bus.stall_request}, 32'h0);
        check("dis_rd1", bus.read_data_1, 32'h0);
        check("dis_rd2_indep", bus.read_data_2, 32'h12345678);
        cyc();
        bus.ex_write_addr = 0; bus.read_en_1 = 1; bus.read_addr_1 = 0;
        settle();
        check("zero_stall", {31'h0, bus.stall_request}, 32'h0);
        check("zero_rd1", bus.read_data_1, 32'h0);

        // Same address on both ports, EX non-load forward.
        cyc(); idle();
        bus.read_en_1 = 1; bus.read_addr_1 = 8;
        bus.read_en_2 = 1; bus.read_addr_2 = 8;
        settle();
        check("same_rd1", bus.read_data_1, 32'h12345678);
        check("same_rd2", bus.read_data_2, 32'h12345678);
        cyc();
        bus.ex_write_en = 1; bus.ex_write_addr = 8; bus.ex_write_data = 32'hCAFE0001;
        settle();
        check("same_ex_rd1", bus.read_data_1, 32'hCAFE0001);
        check("same_ex_rd2", bus.read_data_2, 32'hCAFE0001);

        // Reset mid-operation drops pending write and clears the array.
        cyc(); idle();
        bus.write_en = 1; bus.write_addr = 10; bus.write_data = 32'h0BADF00D;
        cyc();
        rst = 1; bus.write_addr = 11; bus.write_data = 32'h5555AAAA;
        bus.read_en_1 = 1; bus.read_addr_1 = 10;
        settle();
        check("mid_rst_rd1", bus.read_data_1, 32'h0);
        cyc(); rst = 0; idle();
        bus.read_en_1 = 1; bus.read_addr_1 = 10;
        bus.read_en_2 = 1; bus.read_addr_2 = 11;
        settle();
        check("mid_rst_r10", bus.read_data_1, 32'h0);
        check("mid_rst_r11", bus.read_data_2, 32'h0);
        cyc(); idle();
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/reg_file_fwd.md
Name: reg_file_fwd

Overview:
- ID-stage register file, directly downstream of the ID register-address generator.
- Consumes the read enables/addresses (rs/rt) and returns operand data.
- Takes the WB-stage write port.
- Resolves RAW hazards by forwarding from EX/MEM results and requesting a stall on load-use.

Parameters:
DATA_WIDTH, 32, register and data width
ADDR_WIDTH, 5, register address width (2^ADDR_WIDTH registers)

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  synchronous reset, active-high
read_en_1  in  1  read port 1 enable (from RegGen reg_read_en_1)
read_addr_1  in  ADDR_WIDTH  read port 1 address (rs)
read_en_2  in  1  read port 2 enable
read_addr_2  in  ADDR_WIDTH  read port 2 address (rt)
read_data_1  out  DATA_WIDTH  operand 1
read_data_2  out  DATA_WIDTH  operand 2
ex_write_en  in  1  instruction in EX will write a register
ex_write_addr  in  ADDR_WIDTH  EX destination
ex_write_data  in  DATA_WIDTH  EX ALU result
ex_load  in  1  EX instruction is a load (data not yet available)
mem_write_en  in  1  instruction in MEM will write a register
mem_write_addr  in  ADDR_WIDTH  MEM destination
mem_write_data  in  DATA_WIDTH  MEM result (load data valid here)
write_en  in  1  WB write enable
write_addr  in  ADDR_WIDTH  WB destination
write_data  in  DATA_WIDTH  WB data
stall_request  out  1  load-use hazard; ID must hold and insert a bubble

Behaviour:
- Storage: 2^ADDR_WIDTH x DATA_WIDTH array. Register 0 is never written and always reads 0.
- Write: on rising clk with rst=0, write_en=1 and write_addr!=0, reg[write_addr] <= write_data. Writes to address 0 are ignored.
- Reset: synchronous. While rst=1 at a rising edge, all registers clear to 0; any write in that cycle is discarded.
- While rst=1: read_data_1=0, read_data_2=0, stall_request=0 (combinational, regardless of other inputs).
- Reset mid-operation: array is zero from the first post-reset cycle; no pending write survives.
- Read ports are combinational, zero latency. Per port n, the first matching rule applies:
  1. read_en_n=0 -> data 0, no hazard.
  2. read_addr_n=0 -> data 0, no hazard, even if EX/MEM/WB target 0.
  3. ex_write_en=1 and ex_write_addr==read_addr_n:
     - ex_load=1 -> hazard_n=1, data 0.
     - ex_load=0 -> data = ex_write_data.
  4. mem_write_en=1 and mem_write_addr==read_addr_n -> data = mem_write_data.
  5. write_en=1 and write_addr==read_addr_n -> data = write_data (write-through bypass, same cycle as the write).
  6. Otherwise data = reg[read_addr_n].
- Priority EX > MEM > WB ensures the youngest producer wins when several stages target the same register.
- stall_request = hazard_1 | hazard_2. Combinational, asserted for exactly as long as the load sits in EX.
- The block holds no state other than the array. The pipeline controller bubbles EX on stall, so the next cycle resolves via MEM forwarding.
- Both ports may hit the same address simultaneously; both return identical data.
- Both ports are independent; port 2 is unaffected when port 1 is disabled.

Test Plan:
- Reset then read: rst=1 for 2 cycles with write_en=1, addr 5, data 0xDEADBEEF; release; read_en_1=1, addr 5 -> read_data_1=0; stall_request=0 throughout.
- Write/readback and $zero: write 0x12345678 to r8 and 0xFFFFFFFF to r0; next cycle read r8 and r0 -> 0x12345678 and 0.
- WB bypass: same cycle write_en=1, r9, 0xA5A5A5A5 with read_addr_2=9 -> read_data_2=0xA5A5A5A5 combinationally; next cycle array read of r9 matches.
- Forward priority: r3 holds 1; ex (r3, 0x33), mem (r3, 0x22), wb (r3, 0x11) all active -> 0x33. Drop ex -> 0x22. Drop mem -> 0x11.
- Load-use: ex_write_en=1, ex_load=1, ex_addr=4, read_en_2=1, addr 4 -> stall_request=1. Next cycle load moves to MEM with data 0x77 -> stall_request=0, read_data_2=0x77.
- Disabled/zero reads: read_en_1=0, addr 4 with the EX load to r4 active -> stall_request=0, read_data_1=0. read_en_1=1, addr 0 with the EX load targeting r0 -> stall_request=0, data 0.
